cpu_core_param: RTL and testbench
=================================

Name: cpu_core_param

Overview:
- Parametrised multicycle successor to the fixed 16-bit/6-bit-address CPU top.
- Fetches 16-bit instructions from an instruction memory and executes on a register file of configurable width.
- Accesses data memory over request/ready handshakes, so ROM/RAM with wait states are supported.
- Provides a halt state, with a halted flag replacing the old FFFF end-of-execution decode.

Parameters:
DATA_W, 16, register/ALU/data-memory word width (>=8)
PC_W, 6, instruction address width
DADDR_W, 6, data address width; address = low DADDR_W bits of R[SA]

Ports:
clk_main  in  1  clock, all state rising-edge
reset  in  1  asynchronous active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= PC)
imem_data  in  16  instruction word, valid when imem_ready
imem_ready  in  1  fetch completes on a cycle with imem_req & imem_ready
dmem_re  out  1  data read request
dmem_we  out  1  data write request
dmem_addr  out  DADDR_W  data address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data, valid when dmem_ready
dmem_ready  in  1  data access completes on a cycle with (re|we) & ready
halted  out  1  high in HALT state
pc  out  PC_W  current PC (debug)

Behaviour:
- Instruction fields: op=[15:12], DR=[11:8], SA=[7:4], SB=[3:0].
- Register file: 16 x DATA_W, all writable; 2 async read ports, 1 sync write port.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: R[DR]<=R[SA] op R[SB].
  - 5 ADDI: R[DR]<=R[SA]+zero-extended SB.
  - 6 LD: R[DR]<=mem[R[SA]].
  - 7 ST: mem[R[SA]]<=R[SB].
  - 8 BZ: if Z, PC<=PC+sign-extended {DR,SB} (8-bit offset, relative to the already-incremented PC).
  - 9 JMP: PC<=R[SA][PC_W-1:0].
  - F with DR=F: HALT.
  - All other encodings: NOP.
- Arithmetic is modulo 2^DATA_W; no carry/overflow. PC wraps modulo 2^PC_W.
- Z flag: set to (result==0) by opcodes 0-5 and by LD; unchanged by all others.
- FSM states: FETCH, EXEC, MEM, HALT.
  - FETCH: imem_req=1. Wait while !imem_ready. On ready: IR<=imem_data, PC<=PC+1, go to EXEC.
  - EXEC (1 cycle):
    - ALU ops write R[DR] and Z, go to FETCH.
    - BZ/JMP update PC, go to FETCH.
    - LD/ST latch address (and store data) into registers, go to MEM.
    - HALT goes to HALT.
    - NOP goes to FETCH.
  - MEM: dmem_re (LD) or dmem_we (ST) held high with stable addr/wdata until dmem_ready. On ready: LD writes R[DR]<=dmem_rdata and Z; go to FETCH.
  - HALT: terminal; only reset exits. No requests issued; halted=1.
- Requests are never withdrawn before ready. dmem_re and dmem_we are never high together. imem_req is low outside FETCH.
- Latency with zero-wait memories (ready tied high):
  - ALU, branch, NOP: 2 cycles.
  - LD/ST: 3 cycles.
  - Each wait cycle adds 1.
- Reset (any time, including mid-handshake): state=FETCH, PC=0, IR=0, Z=0, all registers=0. Outputs: imem_req=1 once reset deasserts; dmem_re=dmem_we=0; halted=0; pc=0. Any in-flight memory access is abandoned with no register write.
- Writes to R[DR] in the same cycle as a read of R[DR] by the next instruction are not an issue: there is no overlap in the multicycle design.

Test Plan:
- ROM: ADDI R1,R0,5; ADDI R2,R0,3; SUB R3,R1,R2; HALT (FF00). Ready tied high -> R3=2, Z=0, halted=1 after 8 cycles, pc=4.
- ST then LD with dmem_ready delayed 3 cycles:
  - Required: dmem_we held 4 cycles with addr=R[SA], wdata=R[SB].
  - Required: LD returns 0x00AB into R[DR], Z=0.
  - Required: re/we never overlap.
- SUB R1,R1,R1 (Z=1) then BZ offset -2 -> PC loops back. Z=0 case -> falls through to PC+1.
- Wrap: DATA_W=8, ADDI chain 0xFF+1 -> result 0x00, Z=1. JMP to 63 then fetch -> next PC 0.
- Reset asserted mid-MEM (dmem_re high) -> dmem_re drops immediately; R[DR] unchanged at 0; PC=0; fetch restarts at address 0.
- imem_ready low for 5 cycles -> imem_req stays high, imem_addr stable, no state change until ready.

Source files
------------

// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised multicycle CPU with handshaked instruction/data memories.
// States FETCH -> EXEC -> (MEM) -> FETCH; HALT is terminal until reset.
module cpu_core_param #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 6,
    parameter int DADDR_W = 6
) (
    input  logic               clk_main,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_data,
    input  logic               imem_ready,
    output logic               dmem_re,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ready,
    output logic               halted,
    output logic [PC_W-1:0]    pc
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t              state, state_nx;
    logic [PC_W-1:0]     pc_q, pc_nx;
    logic [15:0]         ir;
    logic                z, z_nx;
    logic [DATA_W-1:0]   regs [16];
    logic [DADDR_W-1:0]  maddr;
    logic [DATA_W-1:0]   mwdata;
    logic                rf_we;
    logic [DATA_W-1:0]   rf_wd, alu, ra, rb;
    logic [PC_W-1:0]     off;

    logic [3:0] op, dr, sa, sb;
    assign {op, dr, sa, sb} = ir;
    assign ra  = regs[sa];
    assign rb  = regs[sb];
    // 8-bit branch offset {DR,SB}, sign-extended then fitted to the PC width
    assign off = PC_W'({{PC_W{ir[11]}}, dr, sb});

    always_comb begin
        alu = '0;
        case (op)
            4'd0:    alu = ra + rb;
            4'd1:    alu = ra - rb;
            4'd2:    alu = ra & rb;
            4'd3:    alu = ra | rb;
            4'd4:    alu = ra ^ rb;
            4'd5:    alu = ra + {{(DATA_W-4){1'b0}}, sb};
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        z_nx     = z;
        rf_we    = 1'b0;
        rf_wd    = alu;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    state_nx = EXEC;
                    pc_nx    = pc_q + PC_W'(1);
                end
            end
            EXEC: begin
                state_nx = FETCH;
                if (op <= 4'd5) begin
                    rf_we = 1'b1;
                    z_nx  = (alu == '0);
                end else if (op == 4'd8) begin
                    pc_nx = z ? pc_q + off : pc_q;
                end else if (op == 4'd9) begin
                    pc_nx = ra[PC_W-1:0];
                end else if (op == 4'd6 || op == 4'd7) begin
                    state_nx = MEM;
                end else if (op == 4'hF && dr == 4'hF) begin
                    state_nx = HALT;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    state_nx = FETCH;
                    if (op == 4'd6) begin
                        rf_we = 1'b1;
                        rf_wd = dmem_rdata;
                        z_nx  = (dmem_rdata == '0);
                    end
                end
            end
            default: state_nx = HALT;
        endcase
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            pc_q   <= '0;
            ir     <= '0;
            z      <= 1'b0;
            maddr  <= '0;
            mwdata <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            z     <= z_nx;
            if (state == FETCH && imem_ready) ir <= imem_data;
            // address and store data frozen for the whole MEM handshake
            if (state == EXEC) begin
                maddr  <= ra[DADDR_W-1:0];
                mwdata <= rb;
            end
            if (rf_we) regs[dr] <= rf_wd;
        end
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc_q;
    assign dmem_re    = (state == MEM) && (op == 4'd6);
    assign dmem_we    = (state == MEM) && (op == 4'd7);
    assign dmem_addr  = maddr;
    assign dmem_wdata = mwdata;
    assign halted     = (state == HALT);
    assign pc         = pc_q;
endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: directed bench for cpu_core_param (16-bit main instance, 8-bit wrap instance).
module tb_cpu_core_param;
    logic        clk_main = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, dmem_re, dmem_we, dmem_ready, halted;
    logic        imem_ready = 1'b1;
    logic [5:0]  imem_addr, dmem_addr, pc;
    logic [15:0] imem_data, dmem_wdata, dmem_rdata;

    logic        b_imem_req, b_dmem_re, b_dmem_we, b_halted;
    logic [5:0]  b_imem_addr, b_dmem_addr, b_pc;
    logic [15:0] b_imem_data;
    logic [7:0]  b_dmem_wdata;

    logic [15:0] rom [64];
    logic [15:0] rom8 [64];
    logic [15:0] dmem [64];
    int          dwait = 0;
    int          cnt = 0;
    logic [5:0]  st_addr = '0;
    logic [15:0] st_data = '0;
    int          we_cyc = 0, we_good = 0, re_cyc = 0, overlap = 0;
    int          n_checks = 0, n_fail = 0;

    always #5 clk_main = ~clk_main;

    cpu_core_param dut (
        .clk_main(clk_main), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ready(imem_ready),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .halted(halted), .pc(pc)
    );

    cpu_core_param #(.DATA_W(8)) u8 (
        .clk_main(clk_main), .reset(reset),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_data(b_imem_data), .imem_ready(1'b1),
        .dmem_re(b_dmem_re), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
        .dmem_rdata(8'h00), .dmem_ready(1'b1), .halted(b_halted), .pc(b_pc)
    );

    assign imem_data   = rom[imem_addr];
    assign b_imem_data = rom8[b_imem_addr];
    assign dmem_rdata  = dmem[dmem_addr];
    assign dmem_ready  = (dmem_re | dmem_we) && (cnt >= dwait);

    // data memory wait-state model: ready after dwait request cycles
    always @(posedge clk_main) begin
        cnt <= ((dmem_re | dmem_we) && !dmem_ready) ? cnt + 1 : 0;
        if (dmem_we && dmem_ready) begin
            st_addr <= dmem_addr;
            st_data <= dmem_wdata;
        end
    end

    always @(negedge clk_main) begin
        if (dmem_we) we_cyc <= we_cyc + 1;
        if (dmem_we && dmem_addr == 6'd9 && dmem_wdata == 16'd4) we_good <= we_good + 1;
        if (dmem_re) re_cyc <= re_cyc + 1;
        if (dmem_re && dmem_we) overlap <= overlap + 1;
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b, res;
        logic        z;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_roms();
        for (int i = 0; i < 64; i++) begin
            rom[i]  = 16'hFF00;
            rom8[i] = 16'hFF00;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_main);
        @(negedge clk_main);
        reset = 1'b0;
    endtask

    task automatic run_halt(input int maxc, input string name);
        int k = 0;
        while (!halted && k < maxc) begin
            @(negedge clk_main);
            k++;
        end
        check(name, 32'(halted), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, g0, r0, o0;
        vecs[0]  = '{4'h0, 16'h1234, 16'h0FCC, 16'h2200, 1'b0};
        vecs[1]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[2]  = '{4'h1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0};
        vecs[3]  = '{4'h1, 16'h00AB, 16'h00AB, 16'h0000, 1'b1};
        vecs[4]  = '{4'h2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0};
        vecs[5]  = '{4'h2, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1};
        vecs[6]  = '{4'h3, 16'h1200, 16'h0034, 16'h1234, 1'b0};
        vecs[7]  = '{4'h4, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
        vecs[8]  = '{4'h4, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b1};
        vecs[9]  = '{4'h5, 16'hFFFE, 16'h1111, 16'h0000, 1'b1};
        vecs[10] = '{4'h5, 16'h0010, 16'h1111, 16'h0012, 1'b0};
        vecs[11] = '{4'hA, 16'h1234, 16'h1111, 16'h0000, 1'b0};
        vecs[12] = '{4'hF, 16'h1234, 16'h1111, 16'h0000, 1'b0};
        for (int i = 0; i < 64; i++) dmem[i] = 16'h0000;
        clear_roms();

        #2 reset = 1'b1;
        @(negedge clk_main);
        check("rst pc", 32'(pc), 32'd0);
        check("rst halted", 32'(halted), 32'd0);
        check("rst dmem_re", 32'(dmem_re), 32'd0);
        check("rst dmem_we", 32'(dmem_we), 32'd0);
        check("rst r3", 32'(dut.regs[3]), 32'd0);
        reset = 1'b0;
        #1;
        check("rst imem_req", 32'(imem_req), 32'd1);
        check("rst imem_addr", 32'(imem_addr), 32'd0);

        // LD R1,[R0]; ADDI R4,R0,1; LD R2,[R4]; <op> R3,R1,R2; HALT
        for (int i = 0; i < 13; i++) begin
            clear_roms();
            rom[0] = 16'h6100;
            rom[1] = 16'h5401;
            rom[2] = 16'h6240;
            rom[3] = {vecs[i].op, 12'h312};
            dmem[0] = vecs[i].a;
            dmem[1] = vecs[i].b;
            dwait = 0;
            do_reset();
            run_halt(40, $sformatf("vec%0d halt", i));
            check($sformatf("vec%0d r3", i), 32'(dut.regs[3]), 32'(vecs[i].res));
            check($sformatf("vec%0d z", i), 32'(dut.z), 32'(vecs[i].z));
        end

        clear_roms();
        rom[0] = 16'h5105; rom[1] = 16'h5203; rom[2] = 16'h1312;
        do_reset();
        repeat (7) @(negedge clk_main);
        check("prog1 not yet halted", 32'(halted), 32'd0);
        @(negedge clk_main);
        check("prog1 halted@8", 32'(halted), 32'd1);
        check("prog1 pc", 32'(pc), 32'd4);
        check("prog1 r3", 32'(dut.regs[3]), 32'd2);
        check("prog1 z", 32'(dut.z), 32'd0);
        check("halt no imem_req", 32'(imem_req), 32'd0);

        clear_roms();
        rom[0] = 16'h5109; rom[1] = 16'h5204; rom[2] = 16'h7012; rom[3] = 16'h6300;
        dmem[0] = 16'h00AB;
        dwait = 3;
        do_reset();
        w0 = we_cyc; g0 = we_good; r0 = re_cyc; o0 = overlap;
        run_halt(60, "stld halt");
        @(negedge clk_main);
        check("st we cycles", 32'(we_cyc - w0), 32'd4);
        check("st addr/wdata stable", 32'(we_good - g0), 32'd4);
        check("ld re cycles", 32'(re_cyc - r0), 32'd4);
        check("re/we overlap", 32'(overlap - o0), 32'd0);
        check("st addr", 32'(st_addr), 32'd9);
        check("st data", 32'(st_data), 32'd4);
        check("ld r3", 32'(dut.regs[3]), 32'h00AB);
        check("ld z", 32'(dut.z), 32'd0);

        clear_roms();
        rom[0] = 16'h5101; rom[1] = 16'h1111; rom[2] = 16'h8F0E;
        dwait = 0;
        do_reset();
        repeat (6) @(negedge clk_main);
        check("bz taken pc", 32'(pc), 32'd1);
        check("bz z", 32'(dut.z), 32'd1);
        repeat (4) @(negedge clk_main);
        check("bz loop pc", 32'(pc), 32'd1);

        clear_roms();
        rom[0] = 16'h5101; rom[1] = 16'h8F0E;
        do_reset();
        repeat (4) @(negedge clk_main);
        check("bz not taken pc", 32'(pc), 32'd2);
        run_halt(10, "bz fall halt");
        check("bz fall final pc", 32'(pc), 32'd3);

        clear_roms();
        rom8[0] = 16'h5201; rom8[1] = 16'h1102; rom8[2] = 16'h5311; rom8[3] = 16'h9010;
        do_reset();
        repeat (6) @(negedge clk_main);
        check("w8 r1", 32'(u8.regs[1]), 32'hFF);
        check("w8 r3", 32'(u8.regs[3]), 32'h00);
        check("w8 z", 32'(u8.z), 32'd1);
        repeat (2) @(negedge clk_main);
        check("w8 jmp pc", 32'(b_pc), 32'd63);
        repeat (2) @(negedge clk_main);
        check("w8 pc wrap", 32'(b_pc), 32'd0);
        check("w8 halted", 32'(b_halted), 32'd1);

        clear_roms();
        rom[0] = 16'h6500;
        dmem[0] = 16'h00AB;
        dwait = 50;
        do_reset();
        repeat (2) @(negedge clk_main);
        check("mid re high", 32'(dmem_re), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid re dropped", 32'(dmem_re), 32'd0);
        check("mid pc", 32'(pc), 32'd0);
        check("mid r5", 32'(dut.regs[5]), 32'd0);
        dwait = 0;
        @(negedge clk_main);
        reset = 1'b0;
        #1;
        check("mid restart req", 32'(imem_req), 32'd1);
        check("mid restart addr", 32'(imem_addr), 32'd0);
        @(negedge clk_main);
        check("mid restart pc", 32'(pc), 32'd1);

        clear_roms();
        rom[0] = 16'h5105;
        imem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_main);
            check($sformatf("iwait%0d req", i), 32'(imem_req), 32'd1);
            check($sformatf("iwait%0d addr", i), 32'(imem_addr), 32'd0);
        end
        imem_ready = 1'b1;
        @(negedge clk_main);
        check("iwait fetched pc", 32'(pc), 32'd1);
        @(negedge clk_main);
        check("iwait r1", 32'(dut.regs[1]), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
